// File: rtl/haar_pkg.sv
// Shared descriptor layout and state encoding for the Haar cascade sequencer and feature evaluator.
// Field offsets are LSB positions inside the packed ROM words.
package haar_pkg;

   localparam int FT_TYPE_W = 4;
   localparam int FT_POS_W  = 16;
   localparam int FT_DIM_W  = 16;
   localparam int FT_THR_W  = 20;
   localparam int FEAT_W    = FT_TYPE_W + FT_POS_W + 2 * FT_DIM_W + FT_THR_W + 1;

   localparam int FT_POL_LSB  = 0;
   localparam int FT_THR_LSB  = 1;
   localparam int FT_HGT_LSB  = FT_THR_LSB + FT_THR_W;
   localparam int FT_WID_LSB  = FT_HGT_LSB + FT_DIM_W;
   localparam int FT_POS_LSB  = FT_WID_LSB + FT_DIM_W;
   localparam int FT_TYPE_LSB = FT_POS_LSB + FT_POS_W;

   localparam int ST_FLD_W     = 8;
   localparam int STAGE_W      = 3 * ST_FLD_W;
   localparam int ST_THR_LSB   = 0;
   localparam int ST_NUM_LSB   = 8;
   localparam int ST_FIRST_LSB = 16;

   localparam int NUM_STAGES_DEF = 8;

   typedef enum logic [3:0] {
      IDLE  = 4'd0,
      S_RD  = 4'd1,
      S_CAP = 4'd2,
      F_RD  = 4'd3,
      F_CAP = 4'd4,
      ISSUE = 4'd5,
      WAIT  = 4'd6,
      EVAL  = 4'd7,
      DONE  = 4'd8
   } state_t;

endpackage

// File: rtl/haar_stage_sequencer.sv
// Walks one detection window through the classifier cascade: stage/feature ROM fetch, evaluator issue, vote count, early reject.
// Latency 3 cycles per stage + 4 per feature (+ evaluator latency - 1) + 1; holds in WAIT until f_valid, abort wins over everything.
module haar_stage_sequencer
   import haar_pkg::*;
#(
   parameter int FEAT_AW    = 8,
   parameter int STAGE_AW   = 4,
   parameter int NUM_STAGES = NUM_STAGES_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 abort,
   input  logic [15:0]          window_pos,
   output logic                 busy,
   output logic                 done,
   output logic                 face,
   output logic [STAGE_AW-1:0]  reject_stage,
   output logic [STAGE_AW-1:0]  stage_addr,
   input  logic [STAGE_W-1:0]   stage_data,
   output logic [FEAT_AW-1:0]   feat_addr,
   input  logic [FEAT_W-1:0]    feat_data,
   output logic [FT_TYPE_W-1:0] f_type,
   output logic [FT_POS_W-1:0]  f_position,
   output logic [FT_DIM_W-1:0]  f_width,
   output logic [FT_DIM_W-1:0]  f_height,
   output logic [FT_THR_W-1:0]  f_threshold,
   output logic                 f_polarity,
   output logic                 f_start,
   input  logic                 f_valid,
   input  logic                 f_vote
);

   state_t               state;
   logic [15:0]          win_pos;
   logic [ST_FLD_W-1:0]  num_feat;
   logic [ST_FLD_W-1:0]  vote_thr;
   logic [ST_FLD_W-1:0]  votes;
   logic [ST_FLD_W-1:0]  feat_cnt;

   logic [ST_FLD_W-1:0]  sd_first;
   logic [ST_FLD_W-1:0]  sd_num;
   logic [ST_FLD_W-1:0]  sd_thr;
   logic                 last_stage;
   logic                 stage_pass;

   assign sd_first   = stage_data[ST_FIRST_LSB +: ST_FLD_W];
   assign sd_num     = stage_data[ST_NUM_LSB +: ST_FLD_W];
   assign sd_thr     = stage_data[ST_THR_LSB +: ST_FLD_W];
   assign last_stage = (stage_addr == STAGE_AW'(NUM_STAGES - 1));
   assign stage_pass = (votes >= vote_thr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         win_pos      <= '0;
         num_feat     <= '0;
         vote_thr     <= '0;
         votes        <= '0;
         feat_cnt     <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         face         <= 1'b0;
         reject_stage <= '0;
         stage_addr   <= '0;
         feat_addr    <= '0;
         f_type       <= '0;
         f_position   <= '0;
         f_width      <= '0;
         f_height     <= '0;
         f_threshold  <= '0;
         f_polarity   <= 1'b0;
         f_start      <= 1'b0;
      end else if (abort && state != IDLE) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         f_start <= 1'b0;
      end else begin
         done    <= 1'b0;
         f_start <= 1'b0;
         case (state)
            IDLE: if (start) begin
               win_pos    <= window_pos;
               stage_addr <= '0;
               busy       <= 1'b1;
               state      <= S_RD;
            end
            S_RD: state <= S_CAP;
            S_CAP: begin
               num_feat <= sd_num;
               vote_thr <= sd_thr;
               votes    <= '0;
               feat_cnt <= '0;
               // feat_addr tracks first_feat + feat_cnt incrementally from here on
               if (sd_num != '0) begin
                  feat_addr <= FEAT_AW'(sd_first);
                  state     <= F_RD;
               end else begin
                  state <= EVAL;
               end
            end
            F_RD: state <= F_CAP;
            F_CAP: begin
               f_type      <= feat_data[FT_TYPE_LSB +: FT_TYPE_W];
               f_position  <= feat_data[FT_POS_LSB +: FT_POS_W] + win_pos;
               f_width     <= feat_data[FT_WID_LSB +: FT_DIM_W];
               f_height    <= feat_data[FT_HGT_LSB +: FT_DIM_W];
               f_threshold <= feat_data[FT_THR_LSB +: FT_THR_W];
               f_polarity  <= feat_data[FT_POL_LSB];
               f_start     <= 1'b1;
               state       <= ISSUE;
            end
            ISSUE: state <= WAIT;
            WAIT: if (f_valid) begin
               votes    <= votes + {{(ST_FLD_W-1){1'b0}}, f_vote};
               feat_cnt <= feat_cnt + 8'd1;
               if (feat_cnt == num_feat - 8'd1) begin
                  state <= EVAL;
               end else begin
                  feat_addr <= feat_addr + FEAT_AW'(1);
                  state     <= F_RD;
               end
            end
            EVAL: begin
               if (!stage_pass) begin
                  face         <= 1'b0;
                  reject_stage <= stage_addr;
                  done         <= 1'b1;
                  state        <= DONE;
               end else if (last_stage) begin
                  face         <= 1'b1;
                  reject_stage <= STAGE_AW'(NUM_STAGES);
                  done         <= 1'b1;
                  state        <= DONE;
               end else begin
                  stage_addr <= stage_addr + STAGE_AW'(1);
                  state      <= S_RD;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_haar_stage_sequencer.sv
// Directed bench: two-stage cascade with ROM and evaluator models, hand-computed results and cycle counts.
module tb_haar_stage_sequencer;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic [15:0] window_pos;
   logic        busy, done, face, f_start, f_polarity;
   logic [3:0]  reject_stage, stage_addr;
   logic [23:0] stage_data;
   logic [7:0]  feat_addr;
   logic [72:0] feat_data;
   logic [3:0]  f_type;
   logic [15:0] f_position, f_width, f_height;
   logic [19:0] f_threshold;
   logic        f_valid, f_vote;
   logic [72:0] fcfg;

   logic [23:0] stage_rom [0:15];
   logic [72:0] feat_rom  [0:255];
   bit          vote_rom  [0:255];

   int n_chk = 0;
   int n_err = 0;

   int          ev_lat = 1;
   bit          ev_spur = 0;
   int          ev_cnt = 0;
   bit          ev_vote = 0;
   logic [72:0] ev_snap = '0;
   int          ev_unstable = 0;

   int n_fs, max_sa, fa_n;
   int fa [0:7];
   int cyc;
   bit got;

   haar_stage_sequencer #(.FEAT_AW(8), .STAGE_AW(4), .NUM_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .window_pos(window_pos),
      .busy(busy), .done(done), .face(face), .reject_stage(reject_stage),
      .stage_addr(stage_addr), .stage_data(stage_data),
      .feat_addr(feat_addr), .feat_data(feat_data),
      .f_type(f_type), .f_position(f_position), .f_width(f_width), .f_height(f_height),
      .f_threshold(f_threshold), .f_polarity(f_polarity),
      .f_start(f_start), .f_valid(f_valid), .f_vote(f_vote)
   );

   assign fcfg = {f_type, f_position, f_width, f_height, f_threshold, f_polarity};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // synchronous ROMs: one-cycle read latency
   always @(posedge clk) begin
      stage_data <= stage_rom[stage_addr];
      feat_data  <= feat_rom[feat_addr];
   end

   // evaluator: answers ev_lat cycles after f_start, vote taken from vote_rom by feature address
   always @(negedge clk) begin
      f_valid = 1'b0;
      f_vote  = 1'b0;
      if (ev_cnt > 0) begin
         ev_cnt = ev_cnt - 1;
         if (ev_cnt == 0) begin
            f_valid = 1'b1;
            f_vote  = ev_vote;
            if (fcfg !== ev_snap) ev_unstable = ev_unstable + 1;
         end
      end
      if (f_start) begin
         ev_cnt  = ev_lat;
         ev_vote = vote_rom[feat_addr];
         ev_snap = fcfg;
         if (ev_spur) begin
            f_valid = 1'b1;
            f_vote  = 1'b1;
         end
      end
   end

   task automatic chk(input string tag, input logic [127:0] got_v, input logic [127:0] exp_v);
      n_chk = n_chk + 1;
      if (got_v !== exp_v) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %0h, expected %0h", tag, got_v, exp_v);
      end
   endtask

   function automatic logic [23:0] sd(input logic [7:0] first, input logic [7:0] num, input logic [7:0] thr);
      return {first, num, thr};
   endfunction

   task automatic run(input logic [15:0] pos, input int start_at, input int abort_at,
                      output int ncyc, output bit got_done);
      @(negedge clk);
      chk("idle_before_start", busy, 0);
      window_pos = pos;
      start      = 1'b1;
      n_fs = 0; max_sa = 0; fa_n = 0;
      got_done = 1'b0;
      @(negedge clk);
      start = 1'b0;
      ncyc  = 1;
      chk("busy_rise", busy, 1);
      while (ncyc < 3000) begin
         if (f_start) begin
            n_fs = n_fs + 1;
            if (fa_n < 8) fa[fa_n] = int'(feat_addr);
            fa_n = fa_n + 1;
         end
         if (int'(stage_addr) > max_sa) max_sa = int'(stage_addr);
         if (done) begin
            got_done = 1'b1;
            break;
         end
         if (abort_at != 0 && ncyc >= abort_at + 3) break;
         start = (ncyc == start_at);
         abort = (ncyc == abort_at);
         @(negedge clk);
         ncyc = ncyc + 1;
      end
      start = 1'b0;
      abort = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; window_pos = '0;
      for (int i = 0; i < 16; i++) stage_rom[i] = '0;
      for (int i = 0; i < 256; i++) begin
         feat_rom[i] = '0;
         vote_rom[i] = 1'b0;
      end
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_face", face, 0);
      chk("rst_reject", reject_stage, 0);
      chk("rst_fstart", f_start, 0);
      chk("rst_stage_addr", stage_addr, 0);
      chk("rst_feat_addr", feat_addr, 0);
      chk("rst_fcfg", fcfg, 0);
      rst_n = 1'b1;

      // A: 3 features votes 1,0,1 thr 2 pass; empty stage 1 (thr 0) passes
      stage_rom[0] = sd(8'd0, 8'd3, 8'd2);
      stage_rom[1] = sd(8'd0, 8'd0, 8'd0);
      feat_rom[0] = {4'h1, 16'h0010, 16'h0004, 16'h0002, 20'h00011, 1'b0};
      feat_rom[1] = {4'h2, 16'h0020, 16'h0008, 16'h0004, 20'h00022, 1'b1};
      feat_rom[2] = {4'h3, 16'h0100, 16'h0018, 16'h0008, 20'hABCDE, 1'b1};
      vote_rom[0] = 1'b1; vote_rom[1] = 1'b0; vote_rom[2] = 1'b1;
      ev_lat = 1;
      run(16'h0005, 0, 0, cyc, got);
      chk("A_done", got, 1);
      chk("A_cycles", cyc, 19);
      chk("A_face", face, 1);
      chk("A_reject", reject_stage, 2);
      chk("A_fstarts", n_fs, 3);
      chk("A_fcfg_hold", fcfg, {4'h3, 16'h0105, 16'h0018, 16'h0008, 20'hABCDE, 1'b1});

      // B: thr 3 with votes 1,1,0 rejects at stage 0
      stage_rom[0] = sd(8'd10, 8'd3, 8'd3);
      vote_rom[10] = 1'b1; vote_rom[11] = 1'b1; vote_rom[12] = 1'b0;
      run(16'h0000, 0, 0, cyc, got);
      chk("B_done", got, 1);
      chk("B_cycles", cyc, 16);
      chk("B_face", face, 0);
      chk("B_reject", reject_stage, 0);
      chk("B_max_stage_addr", max_sa, 0);
      chk("B_fstarts", n_fs, 3);
      chk("B_faddr0", fa[0], 10);
      chk("B_faddr1", fa[1], 11);
      chk("B_faddr2", fa[2], 12);

      // D: num_feat 0 with thr 0 passes, thr 1 rejects; run twice back to back
      stage_rom[0] = sd(8'd5, 8'd0, 8'd0);
      stage_rom[1] = sd(8'd5, 8'd0, 8'd1);
      for (int r = 0; r < 2; r++) begin
         run(16'h0000, 0, 0, cyc, got);
         chk("D_done", got, 1);
         chk("D_cycles", cyc, 7);
         chk("D_face", face, 0);
         chk("D_reject", reject_stage, 1);
         chk("D_fstarts", n_fs, 0);
         chk("D_max_stage_addr", max_sa, 1);
      end

      // E: 7-cycle evaluator, spurious f_valid in ISSUE, start during WAIT
      stage_rom[0] = sd(8'd40, 8'd1, 8'd1);
      stage_rom[1] = sd(8'd41, 8'd1, 8'd2);
      feat_rom[40] = {4'h5, 16'h0200, 16'h0010, 16'h0020, 20'h0F0F0, 1'b1};
      feat_rom[41] = {4'h6, 16'h0300, 16'h0030, 16'h0040, 20'h70707, 1'b0};
      vote_rom[40] = 1'b1; vote_rom[41] = 1'b1;
      ev_lat = 7; ev_spur = 1'b1;
      run(16'h0001, 8, 0, cyc, got);
      ev_spur = 1'b0;
      chk("E_done", got, 1);
      chk("E_cycles", cyc, 27);
      chk("E_face", face, 0);
      chk("E_reject", reject_stage, 1);
      chk("E_fstarts", n_fs, 2);
      chk("E_fcfg_stable", ev_unstable, 0);

      // C: window offset wraps, feature address wraps 255 -> 0
      stage_rom[0] = sd(8'd255, 8'd2, 8'd1);
      stage_rom[1] = sd(8'd0, 8'd0, 8'd0);
      feat_rom[255] = {4'hA, 16'h1234, 16'h0001, 16'h0001, 20'h00001, 1'b1};
      feat_rom[0]   = {4'h9, 16'h0020, 16'h0040, 16'h0030, 20'h12345, 1'b0};
      vote_rom[255] = 1'b0; vote_rom[0] = 1'b1;
      ev_lat = 1;
      run(16'hFFF0, 0, 0, cyc, got);
      chk("C_done", got, 1);
      chk("C_cycles", cyc, 15);
      chk("C_face", face, 1);
      chk("C_reject", reject_stage, 2);
      chk("C_faddr0", fa[0], 255);
      chk("C_faddr1", fa[1], 0);
      chk("C_fposition", f_position, 16'h0010);
      chk("C_fcfg", fcfg, {4'h9, 16'h0010, 16'h0040, 16'h0030, 20'h12345, 1'b0});

      // abort in WAIT of stage 1: no done, previous result kept
      stage_rom[0] = sd(8'd40, 8'd1, 8'd1);
      stage_rom[1] = sd(8'd41, 8'd1, 8'd2);
      ev_lat = 7;
      run(16'h0000, 0, 21, cyc, got);
      chk("AB_no_done", got, 0);
      chk("AB_busy", busy, 0);
      chk("AB_fstart", f_start, 0);
      chk("AB_face_kept", face, 1);
      chk("AB_reject_kept", reject_stage, 2);
      chk("AB_reached_stage1", max_sa, 1);
      chk("AB_fstarts", n_fs, 2);
      repeat (10) @(negedge clk);
      chk("AB_still_idle", busy, 0);

      // reset mid-feature with an evaluator result outstanding
      @(negedge clk);
      window_pos = 16'h0100;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      chk("R_busy_before", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("R_busy", busy, 0);
      chk("R_done", done, 0);
      chk("R_face", face, 0);
      chk("R_reject", reject_stage, 0);
      chk("R_fstart", f_start, 0);
      chk("R_stage_addr", stage_addr, 0);
      chk("R_feat_addr", feat_addr, 0);
      chk("R_fcfg", fcfg, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("R_idle_after", busy, 0);
      chk("R_face_after", face, 0);

      // recovery after reset
      stage_rom[0] = sd(8'd5, 8'd0, 8'd0);
      stage_rom[1] = sd(8'd5, 8'd0, 8'd1);
      run(16'h0000, 0, 0, cyc, got);
      chk("R2_done", got, 1);
      chk("R2_cycles", cyc, 7);
      chk("R2_reject", reject_stage, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/haar_stage_sequencer.md
# haar_stage_sequencer

Sequences the Haar-like feature datapath through a cascade of classifier stages for one detection window. Stage and feature descriptors are fetched from two synchronous ROMs, loaded into the feature evaluator's configuration ports, and the evaluator is started once per feature. Votes are counted per stage and compared against the stage vote threshold, with early rejection. The block sits between the window scanner, which issues `start` at integral-image ready, and the feature evaluator.

## Interface
Parameters:
- `FEAT_AW`, 8: feature ROM address width.
- `STAGE_AW`, 4: stage ROM address width.
- `NUM_STAGES`, 8: number of cascade stages; must be ≤ 2^STAGE_AW − 1.

Ports:
- `clk` in 1: single clock for all logic.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin evaluating one window; sampled only in IDLE.
- `abort` in 1: synchronous abandon; returns to IDLE with no `done`.
- `window_pos` in 16: window origin offset, captured at `start`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the result is valid.
- `face` out 1: 1 if all stages passed; held until the next `start`.
- `reject_stage` out STAGE_AW: index of the rejecting stage, or NUM_STAGES on pass; held.
- `stage_addr` out STAGE_AW: stage ROM address.
- `stage_data` in 24: stage descriptor, packed as {first_feat[7:0], num_feat[7:0], vote_thr[7:0]}.
- `feat_addr` out FEAT_AW: feature ROM address.
- `feat_data` in 73: feature descriptor, packed as {type[3:0], position[15:0], width[15:0], height[15:0], threshold[19:0], polarity}.
- `f_type` out 4; `f_position` out 16; `f_width` out 16; `f_height` out 16; `f_threshold` out 20; `f_polarity` out 1: registered evaluator configuration.
- `f_start` out 1: one-cycle pulse that starts the evaluator.
- `f_valid` in 1: evaluator result strobe.
- `f_vote` in 1: evaluator vote, qualified by `f_valid`.

## Operation
- States and transitions:
  - IDLE → S_RD on `start`.
  - S_RD → S_CAP.
  - S_CAP → F_RD if num_feat ≠ 0, else EVAL.
  - F_RD → F_CAP → ISSUE → WAIT.
  - WAIT → F_RD when `f_valid` is high and features remain; WAIT → EVAL when `f_valid` is high on the last feature.
  - EVAL → S_RD when the stage passes and it is not the last stage.
  - EVAL → DONE when the stage fails or the last stage passes.
  - DONE → IDLE.
- ROM reads: address registered and driven in the *_RD state; data sampled at the end of the *_CAP cycle.
- S_CAP captures first_feat, num_feat and vote_thr, and clears the vote counter (8 bit) and feature counter.
- F_CAP loads all `f_*` configuration registers. `f_position` = feat position + `window_pos`, mod 2^16; no saturation.
- `f_*` registers hold their values from F_CAP until the next F_CAP, so the evaluator sees stable configuration through WAIT.
- Feature address = first_feat + feature counter, mod 2^FEAT_AW.
- WAIT: on `f_valid`, vote counter += `f_vote`. It cannot overflow because num_feat ≤ 255.
- Stage pass condition: votes ≥ vote_thr. With num_feat = 0, the stage passes iff vote_thr = 0.
- On fail: `face` ← 0, `reject_stage` ← current stage. On pass of stage NUM_STAGES−1: `face` ← 1, `reject_stage` ← NUM_STAGES.
- `start` outside IDLE is ignored.
- `f_valid` outside WAIT is ignored. `f_valid` coincident with `f_start` is ignored; the earliest accepted strobe is one cycle after `f_start`.
- `abort` is valid in any non-IDLE state and has priority over every other transition. The block returns to IDLE next cycle, `f_start` and `done` stay low, and `face`/`reject_stage` keep their previous values.

## Timing
- All outputs are registered.
- Reset values: state IDLE, `busy` 0, `done` 0, `face` 0, `reject_stage` 0, `f_start` 0, `stage_addr` 0, `feat_addr` 0, all `f_*` 0.
- `busy` rises in the cycle after `start` is sampled.
- Per feature: 4 cycles minimum (F_RD, F_CAP, ISSUE, WAIT), plus (evaluator latency − 1).
- Per stage overhead: 3 cycles (S_RD, S_CAP, EVAL).
- `f_start` is high exactly during ISSUE.
- `done` is high exactly during DONE. `face` and `reject_stage` are updated in EVAL, so they are valid while `done` is high.
- `busy` falls in the cycle after DONE.
- A `start` presented in the cycle `busy` falls is accepted.
- Asserting `rst_n` low mid-operation forces reset values immediately; any outstanding evaluator result is dropped.

## Structure
- Shared package `haar_pkg`:
  - descriptor field widths and offsets (73-bit feature word, 24-bit stage word);
  - state enum encoding;
  - `NUM_STAGES` default.
- The feature descriptor field widths in `haar_pkg` are the same constants the feature evaluator uses.
- No sub-module. The FSM, counters and configuration registers form a single module.

## Test plan
- Single stage (first_feat 0, num_feat 3, vote_thr 2), evaluator votes 1,0,1, NUM_STAGES = 1 → `done` pulse, `face` = 1, `reject_stage` = 1, 3 `f_start` pulses, latency 3 + 3×4 + 1 cycles with immediate `f_valid`.
- Two stages, stage 0 thr 3 with votes 1,1,0 → reject after stage 0: `face` = 0, `reject_stage` = 0, and `stage_addr` never reaches 1.
- `window_pos` = 0xFFF0 with feature position 0x0020 → `f_position` = 0x0010 (wraps mod 2^16).
- Stage with num_feat = 0: vote_thr 0 → passes with no `f_start`; vote_thr 1 → rejects.
- Evaluator delays `f_valid` by 7 cycles; spurious `f_valid` during ISSUE and `start` during WAIT → both ignored, `f_*` stable throughout WAIT, vote counted once.
- `abort` during WAIT of stage 1, then `rst_n` low mid-feature on the next run → after the abort, IDLE with no `done` and the prior `face` retained; after the reset, all outputs at reset values.
